// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Default 640x480 @ 60 Hz raster constants, derived totals and sync
//   windows, the colour types, and a sync-level helper shared by the
//   scanout logic.
//   No ports (package).
package vga_timing_pkg;

  localparam int VGA_CLK_DIV  = 2;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  typedef logic [23:0] colour24_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Active-low sync level: 0 inside [start, stop), 1 elsewhere.
  function automatic logic sync_level(input logic [9:0] cnt,
                                      input logic [9:0] start,
                                      input logic [9:0] stop);
    return !((cnt >= start) && (cnt < stop));
  endfunction

endpackage

// File: rtl/pixel_clock_enable.sv
// pixel_clock_enable
//   Divides the system clock into pixel periods of CLK_DIV clocks.
//   Ports:
//     clk_i      in   system clock
//     rst_n_i    in   synchronous reset, active low
//     pix_en_o   out  one-clk strobe on the last clock of each pixel period
//                     (constantly 1 when CLK_DIV == 1)
//     vga_clk_o  out  DAC pixel clock, high for the first half of each period
module pixel_clock_enable #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic pix_en_o,
  output logic vga_clk_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  // Rounded up so an odd divider gives the longer half to the high phase.
  localparam logic [CW-1:0] HALF     = CW'((CLK_DIV + 1) / 2);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;
  logic          vga_clk_q;

  assign pix_en_o  = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = pix_en_o ? '0 : div_cnt_q + CW'(1);
  assign vga_clk_o = vga_clk_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_cnt_q <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      // Registered from the next count so vga_clk tracks div_cnt_q exactly.
      vga_clk_q <= (div_cnt_d < HALF);
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Raster scan generator and pixel sink for the VGA DAC.
//   Ports:
//     clk          in   system clock
//     rst_n        in   synchronous reset, active low
//     x, y         out  registered pixel coordinates to the colour generator
//                       (0,0 outside the visible area)
//     pixel_data   in   RGB 8:8:8 colour for (x,y), combinational from x/y
//     vga_r/g/b    out  colour, zero while blanked
//     vga_hs/vs    out  syncs, active low
//     vga_blank_n  out  1 on visible pixels
//     vga_sync_n   out  tied 0
//     vga_clk      out  DAC pixel clock
//     frame_tick   out  one-clk pulse as the raster enters vertical blanking
//   Pipeline: counters -> stage 1 (x/y, copies of the counters) -> stage 2
//   (DAC outputs), so every DAC output lags its counter value by two pixel
//   periods and sync, blank and colour stay mutually aligned.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  x,
  output logic [8:0]  y,
  input  logic [23:0] pixel_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_TICK   = 10'(V_ACTIVE - 1);

  logic       pix_en;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       active;

  // Stage 1
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [9:0] hcount_s1_q;
  logic [9:0] vcount_s1_q;
  logic       active_s1_q;

  // Stage 2
  rgb_t       rgb_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_n_q;

  pixel_clock_enable #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clock_enable (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .pix_en_o  (pix_en),
    .vga_clk_o (vga_clk)
  );

  // Next raster position, taken only on pix_en.
  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  assign active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hcount_s1_q <= '0;
      vcount_s1_q <= '0;
      active_s1_q <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
    end else if (pix_en) begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;

      x_q         <= active ? hcount_q : '0;
      y_q         <= active ? vcount_q[8:0] : '0;
      hcount_s1_q <= hcount_q;
      vcount_s1_q <= vcount_q;
      active_s1_q <= active;

      // pixel_data answers the x/y registered one pixel period ago.
      rgb_q       <= active_s1_q ? rgb_t'(pixel_data) : '0;
      hs_q        <= sync_level(hcount_s1_q, HS_START, HS_END);
      vs_q        <= sync_level(vcount_s1_q, VS_START, VS_END);
      blank_n_q   <= active_s1_q;
    end
  end

  // Decoded from registered state so it coincides with the pix_en that
  // moves the counters onto (0, V_ACTIVE); masked while reset is applied.
  assign frame_tick = rst_n && pix_en && (hcount_q == H_LAST) && (vcount_q == V_TICK);

  assign x           = x_q;
  assign y           = y_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic        rst_n = 1'b0;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] pixel_data;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_tick;

  assign pixel_data = {x[7:0], y[7:0], 8'hA5};

  vga_scanout u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .pixel_data  (pixel_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk),
    .frame_tick  (frame_tick)
  );

  // Miniature raster (15 x 8, CLK_DIV=1) so whole frames fit in a short run
  logic        rst_s_n = 1'b0;
  logic [9:0]  s_x;
  logic [8:0]  s_y;
  logic [23:0] s_pd;
  logic [7:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_blank, s_sync, s_vclk, s_tick;

  assign s_pd = {s_x[7:0], s_y[7:0], 8'hA5};

  vga_scanout #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_s_n),
    .x           (s_x),
    .y           (s_y),
    .pixel_data  (s_pd),
    .vga_r       (s_r),
    .vga_g       (s_g),
    .vga_b       (s_b),
    .vga_hs      (s_hs),
    .vga_vs      (s_vs),
    .vga_blank_n (s_blank),
    .vga_sync_n  (s_sync),
    .vga_clk     (s_vclk),
    .frame_tick  (s_tick)
  );

  int checks = 0;
  int errors = 0;
  int cur    = 0;   // clock edges since the last reset release

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Alignment scoreboard: DAC colour must match the x/y seen two clocks
  // (one pixel period) earlier; nonzero x implies a visible pixel.
  logic       sb_on = 1'b0;
  int         sb_n  = 0;
  logic [9:0] xh1, xh2;
  logic [8:0] yh1, yh2;

  task automatic scoreboard();
    logic [23:0] exp_rgb;
    if (sb_n >= 2) begin
      exp_rgb = vga_blank_n ? {xh2[7:0], yh2[7:0], 8'hA5} : 24'h0;
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb || (xh2 != 10'd0 && vga_blank_n !== 1'b1)) begin
        errors++;
        $display("FAIL align: got rgb %06h blank_n %0b, expected rgb %06h for x=%0d y=%0d",
                 {vga_r, vga_g, vga_b}, vga_blank_n, exp_rgb, xh2, yh2);
      end
    end
    xh2 = xh1; yh2 = yh1;
    xh1 = x;   yh1 = y;
    sb_n++;
  endtask

  task automatic step1();
    @(posedge clk);
    cur++;
    #1;
    if (sb_on) scoreboard();
  endtask

  task automatic goto_edge(input int e);
    while (cur < e) step1();
  endtask

  task automatic check_reset_vals();
    chk("rst.x", x, 0);
    chk("rst.y", y, 0);
    chk("rst.rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst.hs", vga_hs, 1);
    chk("rst.vs", vga_vs, 1);
    chk("rst.blank_n", vga_blank_n, 0);
    chk("rst.vga_clk", vga_clk, 0);
    chk("rst.frame_tick", frame_tick, 0);
    chk("rst.sync_n", vga_sync_n, 0);
  endtask

  // Called just after a clock edge; holds reset for n edges, then releases.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    cur = 0;
  endtask

  typedef struct {
    int         e;
    logic [9:0] x;
    logic [8:0] y;
    logic       blank_n;
    logic       hs;
    logic       vs;
    logic       vclk;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mkv(int e, int vx, int vy, logic bl, logic hs, logic vs,
                               logic vc, int r, int g, int b);
    vec_t v;
    v.e = e; v.x = 10'(vx); v.y = 9'(vy); v.blank_n = bl; v.hs = hs; v.vs = vs;
    v.vclk = vc; v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
    return v;
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < NV; i++) begin
      goto_edge(vecs[i].e);
      chk($sformatf("%s%0d.x", tag, i), x, vecs[i].x);
      chk($sformatf("%s%0d.y", tag, i), y, vecs[i].y);
      chk($sformatf("%s%0d.blank_n", tag, i), vga_blank_n, vecs[i].blank_n);
      chk($sformatf("%s%0d.hs", tag, i), vga_hs, vecs[i].hs);
      chk($sformatf("%s%0d.vs", tag, i), vga_vs, vecs[i].vs);
      chk($sformatf("%s%0d.vga_clk", tag, i), vga_clk, vecs[i].vclk);
      chk($sformatf("%s%0d.rgb", tag, i), {vga_r, vga_g, vga_b},
          {vecs[i].r, vecs[i].g, vecs[i].b});
      $display("%s%0d edge %0d: x=%0d y=%0d blank_n=%0b hs=%0b vs=%0b rgb=%06h errors=%0d",
               tag, i, cur, x, y, vga_blank_n, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, errors);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic prev;
    int   t_fall1, t_rise, t_fall2, t_blank_fall;
    int   vs_fall, vs_rise, second_tick, ticks;
    logic prev_vs;
    logic found;

    // Edge e = clock edges after release; DAC shows counter floor(e/2)-2,
    // x/y show counter floor(e/2)-1 (counter c: h = c%800, v = c/800).
    vecs[0]  = mkv(1,    0,   0, 0, 1, 1, 0, 0,   0, 0);
    vecs[1]  = mkv(2,    0,   0, 0, 1, 1, 1, 0,   0, 0);
    vecs[2]  = mkv(3,    0,   0, 0, 1, 1, 0, 0,   0, 0);
    vecs[3]  = mkv(4,    1,   0, 1, 1, 1, 1, 0,   0, 8'hA5);
    vecs[4]  = mkv(6,    2,   0, 1, 1, 1, 1, 1,   0, 8'hA5);
    vecs[5]  = mkv(1282, 0,   0, 1, 1, 1, 1, 127, 0, 8'hA5);
    vecs[6]  = mkv(1284, 0,   0, 0, 1, 1, 1, 0,   0, 0);
    vecs[7]  = mkv(1314, 0,   0, 0, 1, 1, 1, 0,   0, 0);
    vecs[8]  = mkv(1316, 0,   0, 0, 0, 1, 1, 0,   0, 0);
    vecs[9]  = mkv(1506, 0,   0, 0, 0, 1, 1, 0,   0, 0);
    vecs[10] = mkv(1508, 0,   0, 0, 1, 1, 1, 0,   0, 0);
    vecs[11] = mkv(1602, 0,   1, 0, 1, 1, 1, 0,   0, 0);
    vecs[12] = mkv(1604, 1,   1, 1, 1, 1, 1, 0,   1, 8'hA5);
    vecs[13] = mkv(2004, 201, 1, 1, 1, 1, 1, 200, 1, 8'hA5);

    // Reset held for 5 clocks, then table after release
    #1;
    do_reset(5);
    run_table("vec");

    // Line timing with the alignment scoreboard running
    sb_n = 0; sb_on = 1'b1;
    k = 0; prev = vga_hs;
    do begin prev = vga_hs; step1(); k++; end while (!(prev && !vga_hs) && k < 4000);
    chk("line.hs_fall_found", k < 4000, 1);
    t_fall1 = cur;
    k = 0;
    do begin prev = vga_hs; step1(); k++; end while (!(!prev && vga_hs) && k < 4000);
    t_rise = cur;
    k = 0; t_blank_fall = -1;
    do begin
      prev = vga_blank_n;
      step1(); k++;
      if (prev && !vga_blank_n) t_blank_fall = cur;
    end while (!vga_hs == 1'b0 && k < 4000);
    t_fall2 = cur;
    chk("line.hs_low_clks", t_rise - t_fall1, 192);
    chk("line.period_clks", t_fall2 - t_fall1, 1600);
    chk("line.blank_to_hs_clks", t_fall2 - t_blank_fall, 32);
    $display("line: hs low %0d clks, period %0d clks, blank->hs %0d clks",
             t_rise - t_fall1, t_fall2 - t_fall1, t_fall2 - t_blank_fall);
    sb_on = 1'b0;

    // Mid-frame reset for one clock at x=300, y=5
    k = 0;
    while (!(x == 10'd300 && y == 9'd5) && k < 10000) begin step1(); k++; end
    chk("midrst.position_found", k < 10000, 1);
    do_reset(1);
    run_table("post");

    // Miniature raster: frame tick, vsync width, wrap-around
    chk("s_rst.vs", s_vs, 1);
    chk("s_rst.blank_n", s_blank, 0);
    chk("s_rst.tick", s_tick, 0);
    chk("s_rst.sync_n", s_sync, 0);
    rst_s_n = 1'b1;
    k = 0; found = 1'b0;
    while (!found && k < 400) begin
      @(posedge clk); #1; k++;
      if (s_tick) found = 1'b1;
    end
    chk("s.first_tick_edge", k, 59);
    vs_fall = -1; vs_rise = -1; second_tick = -1; ticks = 0; prev_vs = s_vs;
    for (int j = k + 1; j <= 200; j++) begin
      @(posedge clk); #1;
      if (s_tick) begin ticks++; if (second_tick < 0) second_tick = j; end
      if (prev_vs && !s_vs && vs_fall < 0) vs_fall = j;
      if (!prev_vs && s_vs && vs_rise < 0) vs_rise = j;
      prev_vs = s_vs;
      if (j == 60) begin
        chk("s.tick_width", s_tick, 0);
        chk("s.vga_clk_div1", s_vclk, 1);
      end
      if (j == 121) begin
        chk("s.wrap_prev_blank", s_blank, 0);
        chk("s.wrap_xy", {s_x, 1'b0, s_y}, 0);
      end
      if (j == 122) begin
        chk("s.wrap_blank", s_blank, 1);
        chk("s.wrap_rgb", {s_r, s_g, s_b}, 24'h0000A5);
        chk("s.wrap_x_next", s_x, 1);
      end
    end
    chk("s.vs_fall_edge", vs_fall, 77);
    chk("s.vs_rise_edge", vs_rise, 107);
    chk("s.tick_period", second_tick - k, 120);
    chk("s.ticks_in_window", ticks, 1);
    $display("small: tick at %0d and %0d, vs low %0d..%0d",
             k, second_tick, vs_fall, vs_rise);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
